// File: rtl/iterative_shifter_if.sv
// Request/response bundle for the iterative shifter: start/op/operand in, busy/done/result out.
interface iterative_shifter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) ();
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROL): shifts up to STEP positions per cycle,
// with a start/busy/done handshake so the datapath can stall while a shift runs.
module iterative_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    iterative_shifter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [SHAMT_W-1:0] step_k;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    // acc keeps its original MSB under SRA, so the sign fill is always the operand's bit WIDTH-1.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0]   a,
                                                   input logic [1:0]         o,
                                                   input logic [SHAMT_W-1:0] k);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = a << k;
            2'b01:   r = a >> k;
            2'b10:   r = WIDTH'($signed(a) >>> k);
            default: r = (a << k) | (a >> (WIDTH - 32'(k)));
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;

        step_k  = (rem_q < StepAmt) ? rem_q : StepAmt;
        shifted = shift_by(acc_q, op_q, step_k);
        accept  = bus.start && (state_q != StShift);

        case (state_q)
            StShift: begin
                acc_d = shifted;
                rem_d = rem_q - step_k;
                if (rem_q <= StepAmt) begin
                    result_d = shifted;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase

        // A start in IDLE or DONE wins over the default return to IDLE (back-to-back ops).
        if (accept) begin
            acc_d = bus.data_in;
            rem_d = bus.shamt;
            op_d  = bus.op;
            if (bus.shamt == '0) begin
                result_d = bus.data_in;
                state_d  = StDone;
            end else begin
                state_d = StShift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == StShift);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: vector table, scoreboard queue, handshake corners.
module tb_iterative_shifter;
    localparam int W = 32;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    vec_t vecs[12];

    iterative_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                          input logic [4:0] s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return (s == 5'd0) ? d : ((d << s) | (d >> (32 - 32'(s))));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: sample on the falling edge and retire a scoreboard entry on done.
    task automatic tick(output logic saw);
        sb_t e;
        @(negedge clk);
        saw = bus.done;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no pending operation");
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp);
        logic saw;
        sb_t  e;
        int   guard = 0;
        while (bus.busy === 1'b1 && guard < 100) begin
            tick(saw);
            guard++;
        end
        if (guard >= 100) check("busy_timeout", 32'(bus.busy), 32'd0);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.data_in = d;
        bus.shamt   = s;
        e.res     = exp;
        e.acc_cyc = cyc + 1;
        e.lat     = (32'(s) + 3) / 4;
        sb.push_back(e);
        tick(saw);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        logic saw = 1'b0;
        int   guard = 0;
        while (!saw && guard < 100) begin
            tick(saw);
            guard++;
        end
        if (!saw) check("done_timeout", 32'(saw), 32'd1);
    endtask

    task automatic drain();
        logic saw;
        int   guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            tick(saw);
            guard++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic        saw;
        logic [1:0]  ro;
        logic [31:0] rd;
        logic [4:0]  rs;

        vecs[0]  = '{2'b00, 32'd31,        5'd2,  32'd124};
        vecs[1]  = '{2'b00, 32'd5,         5'd2,  32'd20};
        vecs[2]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[3]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[4]  = '{2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018};
        vecs[5]  = '{2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F};
        vecs[6]  = '{2'b10, 32'h7FFF_FFFF, 5'd30, 32'h0000_0001};
        vecs[7]  = '{2'b11, 32'h1234_5678, 5'd31, 32'h091A_2B3C};
        vecs[8]  = '{2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000};
        vecs[9]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF, 5'd4,  32'h0FFF_FFFF};
        vecs[11] = '{2'b11, 32'h0000_00A5, 5'd8,  32'h0000_A500};

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_in = '0;
        bus.shamt   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);

        // SLL 31 by 2: exactly one busy cycle, then done.
        issue(2'b00, 32'd31, 5'd2, 32'd124);
        check("sll2_busy", 32'(bus.busy), 32'd1);
        tick(saw);
        check("sll2_done", 32'(saw), 32'd1);
        check("sll2_busy_off", 32'(bus.busy), 32'd0);
        tick(saw);

        // shamt=0 completes without ever raising busy.
        bus.start = 1'b1; bus.op = 2'b01; bus.data_in = 32'hDEAD_BEEF; bus.shamt = 5'd0;
        sb.push_back('{32'hDEAD_BEEF, cyc + 1, 0});
        tick(saw);
        bus.start = 1'b0;
        check("zero_busy", 32'(bus.busy), 32'd0);
        check("zero_done", 32'(saw), 32'd1);
        tick(saw);

        foreach (vecs[i]) issue(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp);
        drain();

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(3));
            rd = $urandom;
            rs = 5'($urandom_range(31));
            issue(ro, rd, rs, model(ro, rd, rs));
        end
        drain();

        // A start while busy must be ignored and must not disturb the running operation.
        issue(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        tick(saw);
        bus.start = 1'b1; bus.op = 2'b00; bus.data_in = 32'h1; bus.shamt = 5'd1;
        tick(saw);
        bus.start = 1'b0;
        drain();
        repeat (3) tick(saw);

        // Back-to-back: second start presented during the DONE cycle.
        issue(2'b00, 32'd5, 5'd2, 32'd20);
        wait_done();
        issue(2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F);
        drain();
        repeat (2) tick(saw);

        // Reset mid-shift aborts the operation with no done pulse.
        issue(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        repeat (3) tick(saw);
        reset = 1'b1;
        sb.delete();
        tick(saw);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        reset = 1'b0;
        repeat (10) tick(saw);
        issue(2'b11, 32'h8000_0001, 5'd4, 32'h0000_0018);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
